// File: rtl/logic_unit_seq.sv
// Sequential bitwise logic unit: eight logic ops evaluated one SLICE_WIDTH slice
// per cycle behind a start/busy/done handshake; result register loads on completion.
module logic_unit_seq #(
  parameter int unsigned REGISTER_LENGTH = 64,
  parameter int unsigned SLICE_WIDTH     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       start_i,
  input  logic [2:0]                 op_i,
  input  logic [REGISTER_LENGTH-1:0] A_i,
  input  logic [REGISTER_LENGTH-1:0] B_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [REGISTER_LENGTH-1:0] out_o,
  output logic                       zero_o
);

  localparam int unsigned RL         = REGISTER_LENGTH;
  localparam int unsigned SW         = SLICE_WIDTH;
  localparam int unsigned NUM_SLICES = RL / SW;
  localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  if ((SW == 0) || ((RL % SW) != 0)) begin : g_bad_slice
    $error("logic_unit_seq: SLICE_WIDTH must divide REGISTER_LENGTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [SW-1:0] slice_op(input logic [2:0]    op,
                                             input logic [SW-1:0] a,
                                             input logic [SW-1:0] b);
    case (op)
      3'b000:  slice_op = a & b;
      3'b001:  slice_op = a | b;
      3'b010:  slice_op = a ^ b;
      3'b011:  slice_op = ~(a & b);
      3'b100:  slice_op = ~(a | b);
      3'b101:  slice_op = ~(a ^ b);
      3'b110:  slice_op = a & ~b;
      default: slice_op = a;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RL-1:0]   a_q, a_d;
  logic [RL-1:0]   b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [RL-1:0]   work_q, work_d;
  logic [RL-1:0]   out_d;
  logic            zero_d;
  logic            busy_d;
  logic            done_d;

  logic [31:0]     slice_base;
  logic [SW-1:0]   slice_res;
  logic [RL-1:0]   work_merged;

  // Current slice result merged into the work register at bit offset cnt*SW.
  assign slice_base  = 32'(cnt_q) * SW;
  assign slice_res   = slice_op(op_q, SW'(a_q >> slice_base), SW'(b_q >> slice_base));
  assign work_merged = (work_q & ~(RL'({SW{1'b1}}) << slice_base))
                     | (RL'(slice_res) << slice_base);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      work_q  <= '0;
      out_o   <= '0;
      zero_o  <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      work_q  <= work_d;
      out_o   <= out_d;
      zero_o  <= zero_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    work_d  = work_q;
    out_d   = out_o;
    zero_d  = zero_o;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = A_i;
          b_d     = B_i;
          op_d    = op_i;
          cnt_d   = '0;
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d = work_merged;
        // Final slice: publish the complete result in the same edge.
        if (cnt_q == CNT_W'(NUM_SLICES - 1)) begin
          out_d   = work_merged;
          zero_d  = (work_merged == '0);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Randomised bench for logic_unit_seq: timing-level reference model checked every
// cycle, directed literal cases, async reset mid-operation and a parameter sweep.
module tb_logic_unit_seq;

  localparam int unsigned RL = 64;
  localparam int unsigned SW = 16;
  localparam int NS = RL / SW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        busy, done, zero;
  logic [63:0] out;

  logic        s_start;
  logic [2:0]  s_op;
  logic [63:0] s_a, s_b;
  logic        w64_busy, w64_done, w64_zero;
  logic [63:0] w64_out;
  logic        w1_busy, w1_done, w1_zero;
  logic [63:0] w1_out;
  logic        w8_busy, w8_done, w8_zero;
  logic [31:0] w8_out;

  int n_chk = 0;
  int n_fail = 0;

  logic_unit_seq #(.REGISTER_LENGTH(RL), .SLICE_WIDTH(SW)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .op_i(op), .A_i(a), .B_i(b),
    .busy_o(busy), .done_o(done), .out_o(out), .zero_o(zero));

  logic_unit_seq #(.REGISTER_LENGTH(64), .SLICE_WIDTH(64)) u_w64 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(s_start), .op_i(s_op), .A_i(s_a), .B_i(s_b),
    .busy_o(w64_busy), .done_o(w64_done), .out_o(w64_out), .zero_o(w64_zero));

  logic_unit_seq #(.REGISTER_LENGTH(64), .SLICE_WIDTH(1)) u_w1 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(s_start), .op_i(s_op), .A_i(s_a), .B_i(s_b),
    .busy_o(w1_busy), .done_o(w1_done), .out_o(w1_out), .zero_o(w1_zero));

  logic_unit_seq #(.REGISTER_LENGTH(32), .SLICE_WIDTH(8)) u_w8 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(s_start), .op_i(s_op), .A_i(s_a[31:0]),
    .B_i(s_b[31:0]), .busy_o(w8_busy), .done_o(w8_done), .out_o(w8_out), .zero_o(w8_zero));

  function automatic logic [63:0] golden(input logic [2:0] o, input logic [63:0] x,
                                         input logic [63:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: an accepted start at edge t yields done after edge t+NS, busy for
  // edges t..t+NS-1, and the next start is only honoured from edge t+NS+2.
  int          edge_no = 0;
  int          acc = -1;
  logic [63:0] pend = '0;
  logic [63:0] m_out = '0;
  logic        m_zero = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= -1;
      m_out  <= '0;
      m_zero <= 1'b1;
    end else begin
      edge_no <= edge_no + 1;
      if (acc >= 0 && edge_no + 1 == acc + NS) begin
        m_out  <= pend;
        m_zero <= (pend == 64'd0);
      end
      if (start && (acc < 0 || edge_no + 1 >= acc + NS + 2)) begin
        acc  <= edge_no + 1;
        pend <= golden(op, a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(busy), 64'((acc >= 0) && (edge_no >= acc) && (edge_no < acc + NS)));
      chk("done", 64'(done), 64'((acc >= 0) && (edge_no == acc + NS)));
      chk("out", out, m_out);
      chk("zero", 64'(zero), 64'(m_zero));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
  endtask

  // Scrambles operands every cycle; with noise, pulses start at edges 2 and NS+1.
  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      op = 3'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      start = noise && (i == 1 || i == NS);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic sweep(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                       output logic [31:0] r8);
    int l64, l1, l8;
    logic [63:0] r64, r1, g;
    logic z64, z1, z8;
    l64 = 0; l1 = 0; l8 = 0; r64 = '0; r1 = '0; r8 = '0; z64 = 0; z1 = 0; z8 = 0;
    g = golden(o, x, y);
    @(posedge clk); #1;
    s_start = 1'b1; s_op = o; s_a = x; s_b = y;
    @(posedge clk); #1;
    s_start = 1'b0; s_op = 3'($urandom); s_a = {$urandom, $urandom}; s_b = {$urandom, $urandom};
    chk("sw64_busy", 64'(w64_busy), 64'd1);
    chk("sw1_busy", 64'(w1_busy), 64'd1);
    chk("sw8_busy", 64'(w8_busy), 64'd1);
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      s_a = {$urandom, $urandom}; s_b = {$urandom, $urandom};
      if (w64_done && l64 == 0) begin l64 = i; r64 = w64_out; z64 = w64_zero; end
      if (w1_done && l1 == 0) begin l1 = i; r1 = w1_out; z1 = w1_zero; end
      if (w8_done && l8 == 0) begin l8 = i; r8 = w8_out; z8 = w8_zero; end
    end
    chk("sw64_latency", 64'(l64), 64'd1);
    chk("sw1_latency", 64'(l1), 64'd64);
    chk("sw8_latency", 64'(l8), 64'd4);
    chk("sw64_out", r64, g);
    chk("sw1_out", r1, g);
    chk("sw8_out", 64'(r8), 64'(g[31:0]));
    chk("sw1_zero", 64'(z1), 64'(g == 64'd0));
    chk("sw64_zero", 64'(z64), 64'(g == 64'd0));
    chk("sw8_zero", 64'(z8), 64'(g[31:0] == 32'd0));
  endtask

  logic [15:0] tbl [8];
  logic [15:0] t16;
  logic [31:0] r8;
  int          lat;

  initial begin
    start = 0; op = '0; a = '0; b = '0;
    s_start = 0; s_op = '0; s_a = '0; s_b = '0;
    // 16-bit pattern of each op for A=F0F0, B=FF00
    tbl[0] = 16'hF000; tbl[1] = 16'hFFF0; tbl[2] = 16'h0FF0; tbl[3] = 16'h0FFF;
    tbl[4] = 16'h000F; tbl[5] = 16'hF00F; tbl[6] = 16'h00F0; tbl[7] = 16'hF0F0;

    #1 rst_n = 1'b0;
    #2;
    chk("reset_out", out, 64'd0);
    chk("reset_zero", 64'(zero), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // AND with ignored start pulses during RUN and DONE
    issue(3'd0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
    wait_done(1'b1, lat);
    chk("and_latency", 64'(lat), 64'd4);
    chk("and_out", out, 64'h0F0F_0000_0F0F_0000);
    chk("and_zero", 64'(zero), 64'd0);

    // Accepted in the cycle right after done
    issue(3'd2, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    wait_done(1'b0, lat);
    chk("xor_eq_out", out, 64'd0);
    chk("xor_eq_zero", 64'(zero), 64'd1);

    for (int o = 1; o < 8; o++) begin
      issue(3'(o), 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
      wait_done(1'b0, lat);
      t16 = tbl[o];
      chk($sformatf("op%0d_table", o), out, {4{t16}});
    end

    for (int n = 0; n < 24; n++) begin
      logic [2:0]  ro;
      logic [63:0] ra, rb;
      ro = 3'($urandom); ra = {$urandom, $urandom};
      rb = (n % 5 == 0) ? ra : {$urandom, $urandom};
      issue(ro, ra, rb);
      wait_done(1'($urandom), lat);
      chk("rand_latency", 64'(lat), 64'(NS));
      chk("rand_out", out, golden(ro, ra, rb));
    end

    // Async reset two edges into an OR discards it
    issue(3'd7, 64'h0000_0000_0000_00A5, 64'd0);
    wait_done(1'b0, lat);
    chk("pre_reset_out", out, 64'h0000_0000_0000_00A5);
    issue(3'd1, 64'h8000_0000_0000_0001, 64'h0000_FFFF_0000_0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_out", out, 64'd0);
    chk("rst_mid_zero", 64'(zero), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(3'd4, 64'd0, 64'd0);
    wait_done(1'b0, lat);
    chk("nor_after_rst", out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nor_after_rst_zero", 64'(zero), 64'd0);

    sweep(3'd6, 64'h1234_5678_DEAD_BEEF, 64'hFFFF_0000_0000_FFFF, r8);
    chk("sw8_andn_literal", 64'(r8), 64'h0000_0000_DEAD_0000);
    for (int n = 0; n < 3; n++) begin
      sweep(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, r8);
    end

    start = 1'b0;
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
Parametrised, sequential bitwise logic unit for the datapath, generalising the fixed N-bit AND gate. It supports eight selectable logic operations and processes REGISTER_LENGTH-bit operands one SLICE_WIDTH slice per cycle. Control uses a start/busy/done handshake, and the result register is loaded only when the operation completes. It sits beside the ALU as the logic-op execution unit and trades latency for area through SLICE_WIDTH.

Parameters:
REGISTER_LENGTH, 64, operand/result width in bits
SLICE_WIDTH, 16, bits processed per cycle; must divide REGISTER_LENGTH exactly, otherwise elaboration fails
NUM_SLICES (localparam), REGISTER_LENGTH/SLICE_WIDTH, cycles spent in RUN

Ports:
clk_i  input  1  clock, rising edge
reset_ni  input  1  asynchronous, active-low reset
start_i  input  1  request; sampled only in IDLE
op_i  input  3  operation select; sampled with start_i
A_i  input  REGISTER_LENGTH  operand A; sampled with start_i
B_i  input  REGISTER_LENGTH  operand B; sampled with start_i
busy_o  output  1  high while in RUN
done_o  output  1  one-cycle pulse; result valid
out_o  output  REGISTER_LENGTH  registered result; held until the next completion
zero_o  output  1  registered; 1 when out_o == 0

Behaviour:
- Reset (async, reset_ni=0): state=IDLE, slice counter=0, operand/op/work registers=0, out_o=0, zero_o=1, busy_o=0, done_o=0. Reset overrides everything at any time, including mid-RUN; an interrupted operation is discarded and out_o is not updated with partial data.
- Ops (per bit, slice k): 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR; 110 A&~B; 111 pass A. All codes are defined; none are illegal.
- States: IDLE, RUN, DONE.
- IDLE: if start_i=1 at an edge, latch A_i, B_i and op_i, set counter=0, clear the work register, and go to RUN. Otherwise stay in IDLE.
- RUN: each edge writes work[k*SLICE_WIDTH +: SLICE_WIDTH] = op(latched A slice k, latched B slice k) with k=counter, then increments counter. The edge at which counter==NUM_SLICES-1 also loads out_o with the complete result (final slice included), updates zero_o, and goes to DONE. busy_o=1 throughout RUN.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then go unconditionally to IDLE.
- Latency: start sampled at edge 0 -> done_o high in the cycle following edge NUM_SLICES. With SLICE_WIDTH=REGISTER_LENGTH this is the cycle after edge 1.
- start_i in RUN or DONE is ignored: not queued, no effect on latched operands.
- Operands and op_i may change freely after the start edge; only latched values are used.
- out_o and zero_o change only on the completion edge (or reset). They are stable during RUN and hold the previous result. Back-to-back issue rate: one operation per NUM_SLICES+2 cycles.
- Counter width: clog2(NUM_SLICES), minimum 1 bit. The counter never wraps in normal operation because it resets on every new start.

Test Plan:
- AND, REGISTER_LENGTH=64, SLICE_WIDTH=16: A=0xFFFF_0000_FFFF_0000, B=0x0F0F_0F0F_0F0F_0F0F, start at edge 0 -> busy_o high for 4 cycles; done_o pulses after edge 4; out_o=0x0F0F_0000_0F0F_0000; zero_o=0.
- XOR equal operands: A=B=0x1234_5678_9ABC_DEF0 -> out_o=0, zero_o=1. Repeat each of ops 001–111 with A=0xF0F0..., B=0xFF00... and check the per-bit truth table on all 64 bits.
- Handshake: pulse start_i again in cycles 2 and 5 with different A/B -> ignored; done_o pulses once; out_o reflects the first operands. A start in the cycle after done_o is accepted.
- Reset mid-RUN: assert reset_ni=0 asynchronously after edge 2 of an OR -> busy_o=0, done_o=0, out_o=0, zero_o=1 immediately. After release, a new NOR with A=B=0 gives out_o=all ones.
- Stability: during RUN of a second op, out_o keeps the first result until the completion edge; A_i/B_i are toggled randomly after start with no effect on the result.
- Parameter sweep: SLICE_WIDTH=64 -> done_o one cycle after edge 1. SLICE_WIDTH=1 -> done_o after edge 64, results match the golden model. REGISTER_LENGTH=32/SLICE_WIDTH=8 with A&~B: A=0xDEADBEEF, B=0x0000FFFF -> 0xDEAD0000.
